// File: rtl/exe_mem_stage_if.sv
// Execute-to-memory stage bundle: control/data from execute,
// registered results toward memory, and the condition-check port.
interface exe_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              freeze;
   logic              flush;
   logic              valid_in;
   logic              wb_en_in;
   logic              mem_r_en_in;
   logic              mem_w_en_in;
   logic              s_in;
   logic [DATA_W-1:0] alu_res_in;
   logic [DATA_W-1:0] val_rm_in;
   logic [3:0]        dest_in;
   logic [3:0]        nzcv_in;
   logic [3:0]        cond_in;

   logic              valid_out;
   logic              wb_en;
   logic              mem_r_en;
   logic              mem_w_en;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] val_rm;
   logic [3:0]        dest;
   logic [3:0]        status;
   logic              c_to_alu;
   logic              cond_pass;
   logic [CNT_W-1:0]  retired;

   modport slave (
      input  freeze, flush, valid_in,
      input  wb_en_in, mem_r_en_in, mem_w_en_in,
      input  s_in, alu_res_in, val_rm_in,
      input  dest_in, nzcv_in, cond_in,
      output valid_out, wb_en, mem_r_en, mem_w_en,
      output alu_res, val_rm, dest, status,
      output c_to_alu, cond_pass, retired
   );

   modport master (
      output freeze, flush, valid_in,
      output wb_en_in, mem_r_en_in, mem_w_en_in,
      output s_in, alu_res_in, val_rm_in,
      output dest_in, nzcv_in, cond_in,
      input  valid_out, wb_en, mem_r_en, mem_w_en,
      input  alu_res, val_rm, dest, status,
      input  c_to_alu, cond_pass, retired
   );
endinterface

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline register with status flags, condition
// check for decode and a retired-instruction counter.
module exe_mem_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic           clk,
   input  logic           rst,
   exe_mem_stage_if.slave bus
);

   logic              valid_q;
   logic              wb_en_q;
   logic              mem_r_en_q;
   logic              mem_w_en_q;
   logic [DATA_W-1:0] alu_res_q;
   logic [DATA_W-1:0] val_rm_q;
   logic [3:0]        dest_q;
   logic [3:0]        status_q;
   logic [CNT_W-1:0]  retired_q;
   logic              status_we;

   assign status_we = bus.s_in & bus.valid_in
                    & ~bus.freeze & ~bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         alu_res_q  <= '0;
         val_rm_q   <= '0;
         dest_q     <= '0;
      end else if (bus.flush) begin
         valid_q    <= 1'b0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         alu_res_q  <= '0;
         val_rm_q   <= '0;
         dest_q     <= '0;
      end else if (!bus.freeze) begin
         // a bubble must never write, so gate controls here
         valid_q    <= bus.valid_in;
         wb_en_q    <= bus.wb_en_in & bus.valid_in;
         mem_r_en_q <= bus.mem_r_en_in & bus.valid_in;
         mem_w_en_q <= bus.mem_w_en_in & bus.valid_in;
         alu_res_q  <= bus.alu_res_in;
         val_rm_q   <= bus.val_rm_in;
         dest_q     <= bus.dest_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= '0;
      end else if (status_we) begin
         status_q <= bus.nzcv_in;
      end
   end

   // counts what leaves the stage, flushed or not
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
      end else if (valid_q && !bus.freeze) begin
         retired_q <= retired_q + 1'b1;
      end
   end

   logic n_f, z_f, c_f, v_f;
   logic pass;

   assign n_f = status_q[3];
   assign z_f = status_q[2];
   assign c_f = status_q[1];
   assign v_f = status_q[0];

   always_comb begin
      pass = 1'b0;
      unique case (bus.cond_in)
         4'b0000: pass = z_f;
         4'b0001: pass = ~z_f;
         4'b0010: pass = c_f;
         4'b0011: pass = ~c_f;
         4'b0100: pass = n_f;
         4'b0101: pass = ~n_f;
         4'b0110: pass = v_f;
         4'b0111: pass = ~v_f;
         4'b1000: pass = c_f & ~z_f;
         4'b1001: pass = ~c_f | z_f;
         4'b1010: pass = (n_f == v_f);
         4'b1011: pass = (n_f != v_f);
         4'b1100: pass = ~z_f & (n_f == v_f);
         4'b1101: pass = z_f | (n_f != v_f);
         4'b1110: pass = 1'b1;
         4'b1111: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

   assign bus.valid_out = valid_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.mem_r_en  = mem_r_en_q;
   assign bus.mem_w_en  = mem_w_en_q;
   assign bus.alu_res   = alu_res_q;
   assign bus.val_rm    = val_rm_q;
   assign bus.dest      = dest_q;
   assign bus.status    = status_q;
   assign bus.c_to_alu  = status_q[1];
   assign bus.cond_pass = pass;
   assign bus.retired   = retired_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed checks for exe_mem_stage, plus a 4-bit counter
// instance to exercise retired wrap-around.
module tb_exe_mem_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   exe_mem_stage_if #(.DATA_W(32), .CNT_W(32)) bus ();
   exe_mem_stage_if #(.DATA_W(32), .CNT_W(4))  bw ();

   exe_mem_stage #(.DATA_W(32), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exe_mem_stage #(.DATA_W(32), .CNT_W(4)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (bw)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h",
                    tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.freeze      = 0;
      bus.flush       = 0;
      bus.valid_in    = 0;
      bus.wb_en_in    = 0;
      bus.mem_r_en_in = 0;
      bus.mem_w_en_in = 0;
      bus.s_in        = 0;
      bus.alu_res_in  = '0;
      bus.val_rm_in   = '0;
      bus.dest_in     = '0;
      bus.nzcv_in     = '0;
      bus.cond_in     = 4'b1110;
   endtask

   logic [15:0] rst_pass;

   initial begin
      rst_pass = 16'h56AA;
      idle();
      bw.freeze      = 0;
      bw.flush       = 0;
      bw.valid_in    = 0;
      bw.wb_en_in    = 0;
      bw.mem_r_en_in = 0;
      bw.mem_w_en_in = 0;
      bw.s_in        = 0;
      bw.alu_res_in  = '0;
      bw.val_rm_in   = '0;
      bw.dest_in     = '0;
      bw.nzcv_in     = '0;
      bw.cond_in     = '0;

      // reset state
      rst = 1;
      step();
      step();
      check("rst_valid", bus.valid_out, 0);
      check("rst_status", bus.status, 0);
      check("rst_retired", bus.retired, 0);
      check("rst_alu", bus.alu_res, 0);
      for (int i = 0; i < 16; i++) begin
         bus.cond_in = 4'(i);
         #1;
         check($sformatf("rst_cond%0d", i),
               bus.cond_pass, rst_pass[i]);
      end
      rst = 0;

      // basic load
      bus.valid_in   = 1;
      bus.wb_en_in   = 1;
      bus.alu_res_in = 32'h0000_1234;
      bus.val_rm_in  = 32'hCAFE_0001;
      bus.dest_in    = 4'd5;
      step();
      check("ld_valid", bus.valid_out, 1);
      check("ld_wb", bus.wb_en, 1);
      check("ld_alu", bus.alu_res, 32'h1234);
      check("ld_rm", bus.val_rm, 32'hCAFE_0001);
      check("ld_dest", bus.dest, 5);
      check("ld_ret0", bus.retired, 0);
      idle();
      step();
      check("ld_ret1", bus.retired, 1);
      check("ld_bubble", bus.valid_out, 0);

      // flag update and condition check
      bus.valid_in = 1;
      bus.s_in     = 1;
      bus.nzcv_in  = 4'b0110;
      step();
      check("fl_status", bus.status, 4'b0110);
      check("fl_carry", bus.c_to_alu, 1);
      check("fl_ret", bus.retired, 1);
      bus.cond_in = 4'b0000;
      #1;
      check("fl_eq", bus.cond_pass, 1);
      bus.cond_in = 4'b1000;
      #1;
      check("fl_hi", bus.cond_pass, 0);
      bus.s_in    = 0;
      bus.nzcv_in = 4'b1001;
      step();
      check("fl_hold", bus.status, 4'b0110);
      check("fl_ret2", bus.retired, 2);

      // bubble with write intents
      bus.valid_in = 0;
      bus.wb_en_in = 1;
      bus.s_in     = 1;
      bus.nzcv_in  = 4'b1111;
      step();
      check("bb_wb", bus.wb_en, 0);
      check("bb_status", bus.status, 4'b0110);
      check("bb_ret", bus.retired, 3);
      step();
      check("bb_ret_hold", bus.retired, 3);

      // freeze holds everything
      idle();
      bus.valid_in   = 1;
      bus.wb_en_in   = 1;
      bus.alu_res_in = 32'h0000_AAAA;
      bus.dest_in    = 4'd3;
      step();
      check("fz_load", bus.dest, 3);
      bus.freeze = 1;
      bus.s_in   = 1;
      for (int i = 0; i < 3; i++) begin
         bus.dest_in    = 4'(i + 8);
         bus.alu_res_in = 32'h5500 + 32'(i);
         bus.nzcv_in    = 4'(i + 1);
         step();
         check("fz_dest", bus.dest, 3);
         check("fz_alu", bus.alu_res, 32'hAAAA);
         check("fz_valid", bus.valid_out, 1);
         check("fz_ret", bus.retired, 3);
         check("fz_status", bus.status, 4'b0110);
      end

      // flush wins over freeze
      bus.flush       = 1;
      bus.mem_w_en_in = 1;
      bus.nzcv_in     = 4'b1111;
      step();
      check("fs_mw", bus.mem_w_en, 0);
      check("fs_valid", bus.valid_out, 0);
      check("fs_dest", bus.dest, 0);
      check("fs_status", bus.status, 4'b0110);
      check("fs_ret", bus.retired, 3);

      // read and write both set pass through
      idle();
      bus.valid_in    = 1;
      bus.mem_r_en_in = 1;
      bus.mem_w_en_in = 1;
      step();
      check("rw_r", bus.mem_r_en, 1);
      check("rw_w", bus.mem_w_en, 1);
      check("rw_ret", bus.retired, 3);
      idle();
      bus.flush = 1;
      step();
      check("fl_ret_inc", bus.retired, 4);
      check("fl_v", bus.valid_out, 0);

      // build status=1010, retired=7, then reset under freeze
      idle();
      bus.valid_in = 1;
      bus.s_in     = 1;
      bus.nzcv_in  = 4'b1010;
      step();
      check("m_status", bus.status, 4'b1010);
      check("m_carry", bus.c_to_alu, 1);
      bus.s_in = 0;
      for (int i = 0; i < 3; i++) step();
      check("m_ret7", bus.retired, 7);
      rst = 1;
      bus.freeze = 1;
      step();
      check("mr_valid", bus.valid_out, 0);
      check("mr_status", bus.status, 0);
      check("mr_ret", bus.retired, 0);
      check("mr_dest", bus.dest, 0);
      bus.cond_in = 4'b1010;
      #1;
      check("mr_ge", bus.cond_pass, 1);
      rst = 0;
      bus.freeze  = 0;
      bus.dest_in = 4'd9;
      step();
      check("pr_valid", bus.valid_out, 1);
      check("pr_dest", bus.dest, 9);

      // counter wrap on the 4-bit instance
      rst = 1;
      step();
      rst = 0;
      bw.valid_in = 1;
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k == 16) check("wr_15", bw.retired, 15);
         if (k == 17) check("wr_0", bw.retired, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data path width.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 freeze  input  1  hold all registered state (hazard stall).
REQ-006 flush  input  1  squash the instruction entering this stage (branch taken).
REQ-007 valid_in  input  1  execute stage holds a real instruction.
REQ-008 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control bits from execute.
REQ-009 s_in  input  1  instruction updates status flags.
REQ-010 alu_res_in  input  DATA_W  ALU result.
REQ-011 val_rm_in  input  DATA_W  store data.
REQ-012 dest_in  input  4  destination register number.
REQ-013 nzcv_in  input  4  ALU flags {N,Z,C,V}.
REQ-014 cond_in  input  4  condition field of the instruction in decode.
REQ-015 valid_out, wb_en, mem_r_en, mem_w_en  output  1 each  registered control to memory stage.
REQ-016 alu_res, val_rm  output  DATA_W each  registered data.
REQ-017 dest  output  4  registered destination.
REQ-018 status  output  4  status register {N,Z,C,V}.
REQ-019 c_to_alu  output  1  equals status[1]; carry-in for ADC/SBC.
REQ-020 cond_pass  output  1  combinational condition-check result for cond_in.
REQ-021 retired  output  CNT_W  count of valid instructions that left this stage.

Function
REQ-022 Priority on each edge SHALL be rst > flush > freeze > normal load.
REQ-023 Normal load: all pipeline registers capture their _in values; valid_out <= valid_in; latency exactly 1 cycle.
REQ-024 Flush (freeze ignored): valid_out, wb_en, mem_r_en, mem_w_en <= 0; alu_res, val_rm, dest <= 0; status not updated.
REQ-025 Freeze without flush: every register, status and retired SHALL hold.
REQ-026 Control bits wb_en/mem_r_en/mem_w_en SHALL be loaded ANDed with valid_in; a bubble never writes.
REQ-027 status <= nzcv_in only when s_in & valid_in & !freeze & !flush; otherwise hold.
REQ-028 retired increments by 1 on each edge where valid_out==1 and !freeze and !rst; wraps from 2^CNT_W-1 to 0 with no flag.
REQ-029 cond_pass per cond_in using current status: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-030 cond_pass SHALL see the status register value, not nzcv_in (no bypass); decode stalls one cycle after a flag-setting instruction by external hazard logic.
REQ-031 mem_r_en and mem_w_en both 1 at input SHALL be passed through unchanged (no arbitration in this block).

Reset
REQ-032 On rst, every registered output (valid_out, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status, retired) SHALL be 0 on the following edge, regardless of freeze/flush.
REQ-033 Reset mid-stall SHALL clear state; the first post-reset edge with valid_in=1 loads normally.
REQ-034 After reset cond_pass SHALL equal 1 for cond_in in {0001,0011,0101,0111,1001,1010,1100,1110} and 0 otherwise.

Verification
REQ-035 Load: valid_in=1, wb_en_in=1, alu_res_in=0x0000_1234, dest_in=5 -> next cycle valid_out=1, wb_en=1, alu_res=0x1234, dest=5, retired=0; one cycle later retired=1.
REQ-036 Flags: s_in=1, valid_in=1, nzcv_in=0110 -> status=0110, c_to_alu=1; cond_in=0000 -> cond_pass=1; cond_in=1000 -> 0; same with s_in=0, nzcv_in=1001 -> status stays 0110.
REQ-037 Freeze/flush: load dest=3, then freeze=1 three cycles with changing inputs -> outputs and retired hold; freeze=1, flush=1, mem_w_en_in=1 -> mem_w_en=0, valid_out=0, status unchanged.
REQ-038 Bubble: valid_in=0, wb_en_in=1, s_in=1, nzcv_in=1111 -> wb_en=0, status unchanged, retired not incremented.
REQ-039 Wrap: CNT_W=4, 16 valid instructions after reset -> retired sequence reaches 15 then 0.
REQ-040 Reset mid-operation: status=1010, retired=7, rst=1 with freeze=1 -> all outputs 0 next edge; cond_in=1010 -> cond_pass=1.
